// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the two-port RAM burst arbiter.
//   AW / DW / LW : RAM address width, data width, burst length field width
//   state_t      : sequencer state (IDLE waits for a request, BURST issues beats)
//   port_t       : owner id of a burst (0 = CPU side, 1 = DMA side)
package ram_arb_pkg;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic port_t;

endpackage

// File: rtl/ram.sv
// ram: single-port 2^AW x DW memory with a synchronous read register.
//   clock : rising-edge clock
//   addr  : word address
//   wEn   : write enable, wins over rEn when both are high
//   rEn   : read enable, loads rDat with mem[addr] on the next edge
//   wDat  : write data
//   rDat  : read data register, holds its value when not reading; not reset
module ram #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          wEn,
  input  logic          rEn,
  input  logic [DW-1:0] wDat,
  output logic [DW-1:0] rDat
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clock) begin
    if (wEn) begin
      mem[addr] <= wDat;
    end else if (rEn) begin
      rDat <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin burst arbiter and sequencer sharing one RAM
// between a CPU-side requester (m0) and a DMA-side requester (m1).
//   clock, rst_n          : clock, asynchronous active-low reset
//   mx_req/we/addr/len    : burst request and descriptor (len = beats-1)
//   mx_wdata              : write data, consumed in cycles where mx_beat=1
//   mx_gnt                : one-cycle pulse when the request is accepted
//   mx_beat               : one-cycle pulse per RAM access for this port
//   mx_rvalid / mx_rdata  : read return, one cycle after each read beat
//   busy                  : a burst is being issued
module ram_arbiter #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW,
  parameter int LW = ram_arb_pkg::LW
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [LW-1:0] m0_len,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_beat,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [LW-1:0] m1_len,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_beat,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          busy
);

  import ram_arb_pkg::*;

  state_t        state_q, state_d;
  port_t         rr_q, rr_d;
  port_t         own_q, own_d;
  port_t         tag_q, tag_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  port_t         win;
  logic          gnt0, gnt1;
  logic          in_burst;

  logic          ram_wen, ram_ren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat, ram_rdat;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      tag_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      tag_q   <= tag_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    tag_d   = tag_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    // Only contention consults rr; a lone requester wins outright.
    win     = (m0_req && m1_req) ? rr_q : port_t'(m1_req);

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = BURST;
          own_d   = win;
          we_d    = win ? m1_we   : m0_we;
          addr_d  = win ? m1_addr : m0_addr;
          len_d   = win ? m1_len  : m0_len;
          cnt_d   = '0;
          gnt0    = ~win;
          gnt1    = win;
        end
      end
      BURST: begin
        // Natural AW-bit overflow gives the wrap from the top word to 0.
        addr_d = addr_q + 1'b1;
        pend_d = ~we_q;
        tag_d  = own_q;
        if (cnt_q == len_q) begin
          state_d = IDLE;
          rr_d    = ~own_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_burst = (state_q == BURST);
  assign busy     = in_burst;

  // Grant is decoded from live requests, so it must be masked while reset
  // is held or a waiting requester would see a pulse during reset.
  assign m0_gnt    = gnt0 & rst_n;
  assign m1_gnt    = gnt1 & rst_n;
  assign m0_beat   = in_burst & ~own_q;
  assign m1_beat   = in_burst & own_q;
  assign m0_rvalid = pend_q & ~tag_q;
  assign m1_rvalid = pend_q & tag_q;
  assign m0_rdata  = ram_rdat;
  assign m1_rdata  = ram_rdat;

  assign ram_addr = addr_q;
  assign ram_wen  = in_burst & we_q;
  assign ram_ren  = in_burst & ~we_q;
  assign ram_wdat = own_q ? m1_wdata : m0_wdata;

  ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clock (clock),
    .addr  (ram_addr),
    .wEn   (ram_wen),
    .rEn   (ram_ren),
    .wDat  (ram_wdat),
    .rDat  (ram_rdat)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios for ram_arbiter with hand-computed
// expectations. Inputs are driven 2 time units after each rising edge and
// outputs sampled 1 unit later, well away from the edge.
module tb_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [LW-1:0] m0_len, m1_len;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_beat, m0_rvalid, m1_gnt, m1_beat, m1_rvalid, busy;
  logic [DW-1:0] m0_rdata, m1_rdata;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] wbuf [16];
  logic          obs_gnt;
  logic          obs_ogn;
  logic          obs_beat [20];
  logic          obs_busy [20];
  logic          obs_rv   [20];
  logic          obs_oth  [20];
  logic [DW-1:0] obs_rd   [20];

  always #5 clock = ~clock;

  ram_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_len    (m0_len),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_beat   (m0_beat),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_len    (m1_len),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_beat   (m1_beat),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_reqs();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Issue one burst from port p (state must be IDLE) and record what each
  // cycle looks like; c=1..len+1 are beat cycles, c=len+2 the return to IDLE.
  task automatic burst(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [LW-1:0] len);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_len = len;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_len = len;
    end
    #1;
    obs_gnt = (p == 0) ? m0_gnt : m1_gnt;
    obs_ogn = (p == 0) ? m1_gnt : m0_gnt;
    tick();
    clear_reqs();
    for (int c = 1; c <= int'(len) + 2; c++) begin
      if (c - 1 <= int'(len)) begin
        if (p == 0) m0_wdata = wbuf[c-1];
        else        m1_wdata = wbuf[c-1];
      end
      #1;
      obs_beat[c] = (p == 0) ? m0_beat   : m1_beat;
      obs_rv[c]   = (p == 0) ? m0_rvalid : m1_rvalid;
      obs_rd[c]   = (p == 0) ? m0_rdata  : m1_rdata;
      obs_busy[c] = busy;
      obs_oth[c]  = (p == 0) ? (m1_beat | m1_rvalid | m1_gnt)
                             : (m0_beat | m0_rvalid | m0_gnt);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b%b beat=%b%b rv=%b%b busy=%b required all 0",
               m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid, busy);
    end
    clear_reqs();
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got busy=%b gnt=%b%b required 0 00",
               busy, m0_gnt, m1_gnt);
    end
    tick();
  endtask

  task automatic test_write_read();
    logic exp_b, exp_v;
    for (int k = 0; k < 16; k++) wbuf[k] = 32'hA0 + k;
    burst(0, 1'b1, 9'h010, 4'd3);
    checks++;
    if (obs_gnt !== 1'b1 || obs_ogn !== 1'b0) begin
      failures++;
      $display("FAIL wr_gnt got m0=%b m1=%b required 1 0", obs_gnt, obs_ogn);
    end
    for (int c = 1; c <= 5; c++) begin
      exp_b = (c <= 4);
      checks++;
      if (obs_beat[c] !== exp_b || obs_busy[c] !== exp_b || obs_rv[c] !== 1'b0 ||
          obs_oth[c] !== 1'b0) begin
        failures++;
        $display("FAIL wr_beat c=%0d got beat=%b busy=%b rv=%b oth=%b required %b %b 0 0",
                 c, obs_beat[c], obs_busy[c], obs_rv[c], obs_oth[c], exp_b, exp_b);
      end
    end
    burst(0, 1'b0, 9'h010, 4'd3);
    checks++;
    if (obs_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rd_gnt got %b required 1", obs_gnt);
    end
    for (int c = 1; c <= 5; c++) begin
      exp_b = (c <= 4);
      exp_v = (c >= 2);
      checks++;
      if (obs_beat[c] !== exp_b || obs_rv[c] !== exp_v || obs_oth[c] !== 1'b0 ||
          (exp_v && obs_rd[c] !== 32'hA0 + c - 2)) begin
        failures++;
        $display("FAIL rd_data c=%0d got beat=%b rv=%b rdata=%h required %b %b %h",
                 c, obs_beat[c], obs_rv[c], obs_rd[c], exp_b, exp_v, 32'hA0 + c - 2);
      end
    end
  endtask

  task automatic test_contention();
    logic e0, e1, eb, ev0, ev1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010; m0_len = 4'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h011; m1_len = 4'd0;
    // len=0 bursts: grant, beat, then IDLE where the other port wins.
    for (int c = 0; c < 8; c++) begin
      e0  = (c % 4 == 0);
      e1  = (c % 4 == 2);
      eb  = (c % 2 == 1);
      ev0 = (c == 2 || c == 6);
      ev1 = (c == 4);
      #1;
      checks++;
      if (m0_gnt !== e0 || m1_gnt !== e1 || busy !== eb ||
          m0_rvalid !== ev0 || m1_rvalid !== ev1) begin
        failures++;
        $display("FAIL contend c=%0d got gnt=%b%b busy=%b rv=%b%b required %b%b %b %b%b",
                 c, m0_gnt, m1_gnt, busy, m0_rvalid, m1_rvalid, e0, e1, eb, ev0, ev1);
      end
      if (ev0 || ev1) begin
        checks++;
        if (m0_rdata !== (ev0 ? 32'hA0 : 32'hA1)) begin
          failures++;
          $display("FAIL contend_data c=%0d got %h required %h",
                   c, m0_rdata, (ev0 ? 32'hA0 : 32'hA1));
        end
      end
      tick();
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) wbuf[k] = k + 1;
    burst(1, 1'b1, 9'h1FE, 4'd3);
    checks++;
    if (obs_gnt !== 1'b1 || obs_ogn !== 1'b0 || obs_beat[4] !== 1'b1 || obs_beat[5] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_wr got gnt=%b ogn=%b beat4=%b beat5=%b required 1 0 1 0",
               obs_gnt, obs_ogn, obs_beat[4], obs_beat[5]);
    end
    burst(1, 1'b0, 9'h1FE, 4'd3);
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (obs_rv[c] !== 1'b1 || obs_rd[c] !== c - 1 || obs_oth[c] !== 1'b0) begin
        failures++;
        $display("FAIL wrap_rd c=%0d got rv=%b rdata=%h oth=%b required 1 %h 0",
                 c, obs_rv[c], obs_rd[c], obs_oth[c], c - 1);
      end
    end
    burst(1, 1'b0, 9'h000, 4'd1);
    for (int c = 2; c <= 3; c++) begin
      checks++;
      if (obs_rv[c] !== 1'b1 || obs_rd[c] !== c + 1) begin
        failures++;
        $display("FAIL wrap_low c=%0d got rv=%b rdata=%h required 1 %h",
                 c, obs_rv[c], obs_rd[c], c + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_d;
    for (int k = 0; k < 16; k++) wbuf[k] = 32'hEE;
    burst(0, 1'b1, 9'h040, 4'd7);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h040; m0_len = 4'd7;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt got %b required 1", m0_gnt);
    end
    tick();
    clear_reqs();
    m0_wdata = 32'h50;
    tick();
    m0_wdata = 32'h51;
    tick();
    m0_wdata = 32'h52;
    m0_req = 1'b1; m1_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid, busy} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got gnt=%b%b beat=%b%b rv=%b%b busy=%b required all 0",
               m0_gnt, m1_gnt, m0_beat, m1_beat, m0_rvalid, m1_rvalid, busy);
    end
    tick();
    m0_we = 1'b0; m0_addr = 9'h040; m0_len = 4'd7;
    m1_we = 1'b0; m1_addr = 9'h000; m1_len = 4'd0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL mid_rr_reset got gnt=%b%b required 10", m0_gnt, m1_gnt);
    end
    tick();
    clear_reqs();
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (c >= 2) begin
        exp_d = (c - 2 < 2) ? 32'h50 + c - 2 : 32'hEE;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d) begin
          failures++;
          $display("FAIL mid_readback c=%0d got rv=%b rdata=%h required 1 %h",
                   c, m0_rvalid, m0_rdata, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_late();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h020; m0_len = 4'd1;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL late_m0_gnt got %b required 1", m0_gnt);
    end
    tick();
    clear_reqs();
    m0_wdata = 32'h77;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h020; m1_len = 4'd0;
    #1;
    checks++;
    if (m1_gnt !== 1'b0 || m0_beat !== 1'b1) begin
      failures++;
      $display("FAIL late_beat0 got m1_gnt=%b m0_beat=%b required 0 1", m1_gnt, m0_beat);
    end
    tick();
    m0_wdata = 32'h78;
    #1;
    checks++;
    if (m1_gnt !== 1'b0 || m0_beat !== 1'b1) begin
      failures++;
      $display("FAIL late_beat1 got m1_gnt=%b m0_beat=%b required 0 1", m1_gnt, m0_beat);
    end
    tick();
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL late_m1_gnt got m1=%b m0=%b busy=%b required 1 0 0", m1_gnt, m0_gnt, busy);
    end
    tick();
    m1_req = 1'b0;
    #1;
    checks++;
    if (m1_beat !== 1'b1 || m0_beat !== 1'b0) begin
      failures++;
      $display("FAIL late_m1_beat got m1=%b m0=%b required 1 0", m1_beat, m0_beat);
    end
    tick();
    #1;
    checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'h77) begin
      failures++;
      $display("FAIL late_m1_data got rv=%b m0rv=%b rdata=%h required 1 0 00000077",
               m1_rvalid, m0_rvalid, m1_rdata);
    end
    tick();
  endtask

  task automatic test_dropped();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h060; m1_len = 4'd2;
    m1_wdata = 32'h61;
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL drop_m1_gnt got %b required 1", m1_gnt);
    end
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h060; m0_len = 4'd0;
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || m1_beat !== 1'b1) begin
      failures++;
      $display("FAIL drop_during got m0_gnt=%b m1_beat=%b required 0 1", m0_gnt, m1_beat);
    end
    tick();
    m0_req = 1'b0;
    m1_wdata = 32'h62;
    tick();
    m1_wdata = 32'h63;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({m0_gnt, m0_beat, m0_rvalid, busy, m1_beat} !== 5'b0) begin
        failures++;
        $display("FAIL drop_after c=%0d got gnt=%b beat=%b rv=%b busy=%b m1_beat=%b required all 0",
                 c, m0_gnt, m0_beat, m0_rvalid, busy, m1_beat);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_len = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_len = '0; m1_wdata = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_late();
    test_dropped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
